reg_write_arbiter: RTL and testbench

Round-robin write arbiter for the shared register bank built from enabled D flip-flops (`dflipflop` with `clk`, `enable`, `reset`, `data`, `q`). Up to NREQ requesters compete for write access; the arbiter selects one per transaction, latches its address and data, and drives a one-cycle one-hot enable into the bank with the shared data bus. It sits between the requesting datapath units and the flip-flop bank and is the only block that asserts bank enables.

---
 rtl/reg_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 47 ++++
 rtl/reg_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
//   Shared types and constants for the register-bank write arbiter.
//   - arb_state_t : arbiter FSM state (IDLE, WRITE)
//   - CNT_W       : width of the optional completed-write counter
//   - addr_width  : index width needed to address n items (minimum 1 bit)
// ---------------------------------------------------------------------------
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

    localparam int CNT_W = 16;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Scans req starting at ptr, moving
//   upward and wrapping from NREQ-1 back to 0; the first set bit wins.
// Ports:
//   req        in   NREQ  request vector
//   ptr        in   PW    index with highest priority this round
//   win_onehot out  NREQ  one-hot winner (all zero when no request)
//   win_idx    out  PW    binary winner index (0 when no request)
//   valid      out  1     at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = addr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_onehot,
    output logic [PW-1:0]   win_idx,
    output logic            valid
);

    int          cand;
    logic [PW-1:0] cand_idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        valid      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(ptr) + k) % NREQ;
            cand_idx = PW'(cand);
            if (!valid && req[cand_idx]) begin
                valid                = 1'b1;
                win_idx              = cand_idx;
                win_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//   Round-robin write arbiter in front of a bank of enabled D flip-flops.
//   One requester is granted per transaction; its address and data are
//   latched and presented to the bank as a one-cycle one-hot enable plus a
//   shared data bus. Each transaction is IDLE (arbitrate) then WRITE (one
//   cycle), so the block sustains one write every two cycles.
//
//   Optional feature macro: ARB_COUNT_EN adds the write_count port and a
//   16-bit wrapping counter of completed writes.
//
// Ports:
//   clk          in   1           rising-edge clock
//   reset        in   1           synchronous, active-low reset
//   req          in   NREQ        level requests, held until granted
//   req_addr     in   NREQ*AW     packed addresses, requester i at [i*AW +: AW]
//   req_data     in   NREQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
//   gnt          out  NREQ        one-hot grant, high during WRITE
//   reg_en       out  NREG        one-hot bank enable, high during WRITE
//   reg_data     out  WIDTH       bank data bus, holds last written value
//   busy         out  1           high during WRITE
//   write_count  out  16          completed writes (ARB_COUNT_EN only)
// ---------------------------------------------------------------------------
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NREG  = 8,
    parameter int WIDTH = 8,
    parameter int AW    = addr_width(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREG-1:0]       reg_en,
    output logic [WIDTH-1:0]      reg_data,
    output logic                  busy
`ifdef ARB_COUNT_EN
    ,
    output logic [CNT_W-1:0]      write_count
`endif
);

    localparam int PW = addr_width(NREQ);

    arb_state_t      state_q, state_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_q;

    logic [NREQ-1:0] pick_onehot;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;

    logic [AW-1:0]   sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic            start;
    logic            done;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .valid      (pick_valid)
    );

    // Winner's address/data slices of the packed request buses.
    always_comb begin
        sel_addr = req_addr[int'(pick_idx)*AW +: AW];
        sel_data = req_data[int'(pick_idx)*WIDTH +: WIDTH];
    end

    // Next-state logic; arbitration only happens in IDLE, so request
    // changes while in WRITE have no effect on the latched transaction.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    start   = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q    <= '0;
            win_q    <= '0;
            gnt      <= '0;
            reg_en   <= '0;
            reg_data <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            win_q    <= pick_idx;
            gnt      <= pick_onehot;
            reg_en   <= NREG'(1) << sel_addr;
            reg_data <= sel_data;
            busy     <= 1'b1;
        end else if (done) begin
            // Winner's successor gets top priority next round.
            ptr_q  <= (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
            gnt    <= '0;
            reg_en <= '0;
            busy   <= 1'b0;
        end
    end

`ifdef ARB_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // A write cut short by reset is still captured by the bank but is not
    // counted, because the reset branch takes priority at that edge.
    always_ff @(posedge clk) begin
        if (!reset)    cnt_q <= '0;
        else if (done) cnt_q <= cnt_q + 1'b1;
    end

    assign write_count = cnt_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//   Self-checking bench for reg_write_arbiter: directed scenarios followed by
//   randomized requests, compared every cycle against a transaction-level
//   reference model. A behavioural register bank driven by reg_en/reg_data
//   stands in for the flip-flop bank.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int NREG  = 8;
    localparam int WIDTH = 8;
    localparam int AW    = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREG-1:0]       reg_en;
    logic [WIDTH-1:0]      reg_data;
    logic                  busy;
`ifdef ARB_COUNT_EN
    logic [15:0]           write_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .NREQ  (NREQ),
        .NREG  (NREG),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .gnt         (gnt),
        .reg_en      (reg_en),
        .reg_data    (reg_data),
        .busy        (busy)
`ifdef ARB_COUNT_EN
        ,
        .write_count (write_count)
`endif
    );

    // Behavioural flip-flop bank: captures whenever its enable is high.
    logic [WIDTH-1:0] bank [NREG];
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++)
            if (reg_en[i]) bank[i] <= reg_data;
    end

    // Reference model: one pending transaction at most.
    bit              m_busy;
    int              m_ptr, m_w, m_addr, m_cnt;
    logic [WIDTH-1:0] m_data, m_regdata;
    logic [WIDTH-1:0] bmodel [NREG];
    int              wr_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int addr, input int data);
        req[i]                  = 1'b1;
        req_addr[i*AW +: AW]    = AW'(addr);
        req_data[i*WIDTH +: WIDTH] = WIDTH'(data);
    endtask

    // Applies the arbiter's rules for one clock edge using the inputs
    // present at that edge.
    task automatic model_step();
        wr_addr = -1;
        if (m_busy) begin
            bmodel[m_addr] = m_data;
            wr_addr        = m_addr;
        end
        if (!reset) begin
            m_busy    = 0;
            m_ptr     = 0;
            m_regdata = '0;
            m_cnt     = 0;
        end else if (m_busy) begin
            m_ptr  = (m_w + 1) % NREQ;
            m_busy = 0;
            m_cnt  = (m_cnt + 1) % 65536;
        end else if (req != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i = (m_ptr + k) % NREQ;
                if (req[i]) begin
                    m_w = i;
                    break;
                end
            end
            m_addr    = int'(req_addr[m_w*AW +: AW]);
            m_data    = req_data[m_w*WIDTH +: WIDTH];
            m_regdata = m_data;
            m_busy    = 1;
        end
    endtask

    task automatic compare_all();
        check("gnt",      32'(gnt),      m_busy ? 32'(1) << m_w    : 32'd0);
        check("reg_en",   32'(reg_en),   m_busy ? 32'(1) << m_addr : 32'd0);
        check("reg_data", 32'(reg_data), 32'(m_regdata));
        check("busy",     32'(busy),     32'(m_busy));
        if (wr_addr >= 0)
            check("bank", 32'(bank[wr_addr]), 32'(bmodel[wr_addr]));
`ifdef ARB_COUNT_EN
        check("write_count", 32'(write_count), 32'(m_cnt));
`endif
    endtask

    // Inputs are driven at negedge; the model steps on the same edge the
    // DUT uses, and outputs are compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        m_busy = 0; m_ptr = 0; m_w = 0; m_addr = 0; m_cnt = 0;
        m_data = '0; m_regdata = '0;
        @(negedge clk);

        // Reset held with all requests active: nothing may be granted.
        req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_gnt",  32'(gnt),      32'd0);
            check("rst_en",   32'(reg_en),   32'd0);
            check("rst_busy", 32'(busy),     32'd0);
            check("rst_data", 32'(reg_data), 32'd0);
        end

        // Single write from requester 2.
        reset = 1'b1;
        req   = '0;
        set_req(2, 5, 8'hA5);
        tick();
        check("single_gnt",  32'(gnt),      32'b0100);
        check("single_en",   32'(reg_en),   32'b0010_0000);
        check("single_data", 32'(reg_data), 32'hA5);
        req = '0;
        tick();
        check("single_bank", 32'(bank[5]),  32'hA5);
        check("single_idle", 32'(busy),     32'd0);

        // Pointer wrap: grant to 3, then 1001 -> 0, then 1001 -> 3.
        req = 4'b1000;
        tick();
        check("wrap_g3", 32'(gnt), 32'b1000);
        req = '0;
        tick();
        req = 4'b1001;
        tick();
        check("wrap_g0", 32'(gnt), 32'b0001);
        tick();
        tick();
        check("wrap_g3b", 32'(gnt), 32'b1000);
        tick();

        // Round-robin with all requests held, starting from pointer 0.
        reset = 1'b0;
        req   = '0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 8'h10 + i);
        for (int t = 0; t < 10; t++) begin
            tick();
            check("rr_gnt", 32'(gnt), (t % 2 == 0) ? 32'(1) << ((t / 2) % NREQ) : 32'd0);
        end

        // Reset at the edge ending a write from requester 1.
        req = '0;
        tick();
        set_req(1, 6, 8'h3C);
        tick();
        check("mid_gnt", 32'(gnt), 32'b0010);
        reset = 1'b0;
        req   = '0;
        tick();
        check("mid_bank", 32'(bank[6]), 32'h3C);
        reset = 1'b1;
        req   = 4'b0011;
        tick();
        check("mid_ptr", 32'(gnt), 32'b0001);
`ifdef ARB_COUNT_EN
        check("mid_cnt", 32'(write_count), 32'd0);
`endif
        req = '0;
        tick();

`ifdef ARB_COUNT_EN
        // Counter wrap from a back-door preload.
        force dut.cnt_q = 16'd65534;
        #1;
        release dut.cnt_q;
        m_cnt = 65534;
        for (int n = 0; n < 2; n++) begin
            set_req(0, n, 8'h50 + n);
            tick();
            req = '0;
            tick();
            check("cnt_wrap", 32'(write_count), (n == 0) ? 32'd65535 : 32'd0);
        end
`endif

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 63) != 0);
            req      = NREQ'($urandom);
            req_addr = (NREQ*AW)'($urandom);
            req_data = (NREQ*WIDTH)'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
